// File: rtl/dram_pkg.sv
// Shared encodings for the byte-serial data memory load/store unit.
// FUNCT3 codes, FSM states, access size decode and load extension.
package dram_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_RESP
  } state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] n;
  } size_t;

  function automatic size_t f3_size(input logic [2:0] f3);
    size_t s;
    s.ok = 1'b1;
    s.n  = 3'd1;
    case (f3)
      F3_B, F3_BU: s.n = 3'd1;
      F3_H, F3_HU: s.n = 3'd2;
      F3_W:        s.n = 3'd4;
      default: begin
        s.ok = 1'b0;
        s.n  = 3'd1;
      end
    endcase
    return s;
  endfunction

  function automatic logic [31:0] extend(
    input logic [2:0]  f3,
    input logic [31:0] raw
  );
    logic [31:0] r;
    r = raw;
    case (f3)
      F3_B:  r = {{24{raw[7]}}, raw[7:0]};
      F3_BU: r = {24'd0, raw[7:0]};
      F3_H:  r = {{16{raw[15]}}, raw[15:0]};
      F3_HU: r = {16'd0, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dram_lsu_if.sv
// Request/response bundle between the execute stage and dram_lsu.
// master drives requests, slave services them.
interface dram_lsu_if #(
  parameter int ADDR_W = 10,
  parameter int XLEN   = 32
);
  logic              REQ;
  logic              WE;
  logic [2:0]        FUNCT3;
  logic [ADDR_W-1:0] ADDR;
  logic [XLEN-1:0]   WDATA;
  logic              BUSY;
  logic              DONE;
  logic [XLEN-1:0]   RDATA;
  logic              ERR;

  modport master (
    output REQ, WE, FUNCT3, ADDR, WDATA,
    input  BUSY, DONE, RDATA, ERR
  );

  modport slave (
    input  REQ, WE, FUNCT3, ADDR, WDATA,
    output BUSY, DONE, RDATA, ERR
  );
endinterface

// File: rtl/dram_byte_array.sv
// DEPTH x 8 storage: combinational read, synchronous write, no reset.
// Contents survive reset of the sequencer.
module dram_byte_array #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              CLK,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [7:0]        WDATA,
  output logic [7:0]        RDATA
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (WE) mem[ADDR] <= WDATA;
  end

  assign RDATA = mem[ADDR];

endmodule

// File: rtl/dram_lsu.sv
// Byte-serial RV32 load/store sequencer over a byte-wide data memory.
// Define DRAM_LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses.
module dram_lsu
  import dram_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1 << ADDR_W,
  parameter int XLEN   = 32
) (
  input  logic      CLK,
  input  logic      RST,
  dram_lsu_if.slave bus
);

  state_t state;
  state_t nstate;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        n_q;
  logic [1:0]        idx;
  logic [31:0]       asm_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  size_t             req_sz;
  logic              misal;
  logic              reject;
  logic              last;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic [31:0]       merged;

  assign req_sz = f3_size(bus.FUNCT3);

  always_comb begin
    misal = 1'b0;
`ifdef DRAM_LSU_MISALIGN_TRAP_EN
    case (bus.FUNCT3)
      F3_H, F3_HU: misal = bus.ADDR[0];
      F3_W:        misal = |bus.ADDR[1:0];
      default:     misal = 1'b0;
    endcase
`else
    misal = 1'b0;
`endif
  end

  assign reject = !req_sz.ok || misal;

  // Byte i of the access lives at addr+i, wrapping modulo DEPTH.
  assign mem_addr  = addr_q + ADDR_W'(idx);
  assign mem_we    = (state == S_XFER) && we_q;
  assign mem_wdata = wdata_q[{idx, 3'b000} +: 8];
  assign last      = ({1'b0, idx} == (n_q - 3'd1));

  always_comb begin
    merged = asm_q;
    merged[{idx, 3'b000} +: 8] = mem_rdata;
  end

  dram_byte_array #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .WE    (mem_we),
    .ADDR  (mem_addr),
    .WDATA (mem_wdata),
    .RDATA (mem_rdata)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: begin
        if (bus.REQ) nstate = reject ? S_RESP : S_XFER;
      end
      S_XFER: begin
        if (last) nstate = S_RESP;
      end
      S_RESP:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      n_q     <= 3'd1;
      idx     <= 2'd0;
      asm_q   <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.REQ) begin
            we_q    <= bus.WE;
            f3_q    <= bus.FUNCT3;
            addr_q  <= bus.ADDR;
            wdata_q <= bus.WDATA;
            n_q     <= req_sz.n;
            idx     <= 2'd0;
            asm_q   <= 32'd0;
            err_q   <= reject;
          end
        end
        S_XFER: begin
          idx <= idx + 2'd1;
          if (!we_q) begin
            asm_q <= merged;
            if (last) rdata_q <= extend(f3_q, merged);
          end
        end
        S_RESP: begin
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.BUSY  = (state != S_IDLE);
  assign bus.DONE  = (state == S_RESP);
  assign bus.ERR   = err_q;
  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_dram_lsu.sv
// Scoreboard bench for dram_lsu: directed loads/stores, errors,
// wrap-around, mid-access reset and held REQ.
module tb_dram_lsu;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  dram_lsu_if #(.ADDR_W(10), .XLEN(32)) bus ();

  dram_lsu #(.ADDR_W(10), .XLEN(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef DRAM_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;
  localparam logic [2:0] BU = 3'b100;
  localparam logic [2:0] HU = 3'b101;

  typedef struct {
    bit          err;
    logic [31:0] rd;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          busy_run = 0;
  logic [31:0] exp_last = 32'd0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, req);
    end
  endtask

  function automatic int nbytes(logic [2:0] f3);
    if (f3 == W) return 4;
    if (f3 == H || f3 == HU) return 2;
    return 1;
  endfunction

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) busy_run = 0;
      else begin
        busy_run = bus.BUSY ? busy_run + 1 : 0;
        if (bus.DONE) begin
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got DONE=1 want none");
          end else begin
            e = sbq.pop_front();
            chk("err", 32'(bus.ERR), 32'(e.err));
            chk("rdata", bus.RDATA, e.rd);
            chk("latency", 32'(cyc), 32'(e.cyc));
            chk("busy_len", 32'(busy_run), 32'(e.busy));
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge CLK);
    while (bus.BUSY && k < 50) begin
      @(negedge CLK);
      k++;
    end
    if (bus.BUSY) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout got BUSY=1 want 0");
    end
  endtask

  task automatic push_exp(bit err, logic [31:0] rd, bit we, int n);
    exp_t e;
    if (!we && !err) exp_last = rd;
    e.err  = err;
    e.rd   = exp_last;
    e.cyc  = cyc + (err ? 0 : n);
    e.busy = err ? 1 : n + 1;
    sbq.push_back(e);
  endtask

  task automatic issue(bit we, logic [2:0] f3, logic [9:0] a,
                       logic [31:0] wd, bit err, logic [31:0] rd);
    wait_idle();
    bus.REQ    = 1'b1;
    bus.WE     = we;
    bus.FUNCT3 = f3;
    bus.ADDR   = a;
    bus.WDATA  = wd;
    @(posedge CLK);
    #1;
    bus.REQ = 1'b0;
    push_exp(err, rd, we, nbytes(f3));
  endtask

  task automatic st(logic [2:0] f3, logic [9:0] a, logic [31:0] wd, bit err);
    issue(1'b1, f3, a, wd, err, 32'd0);
  endtask

  task automatic ld(logic [2:0] f3, logic [9:0] a, logic [31:0] rd, bit err);
    issue(1'b0, f3, a, 32'd0, err, rd);
  endtask

  initial begin : stim
    int k;
    bus.REQ    = 1'b0;
    bus.WE     = 1'b0;
    bus.FUNCT3 = 3'b000;
    bus.ADDR   = 10'd0;
    bus.WDATA  = 32'd0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_err", 32'(bus.ERR), 32'd0);
    chk("rst_rdata", bus.RDATA, 32'd0);
    RST = 1'b0;

    st(W, 10'h004, 32'hDEADBEEF, 1'b0);
    ld(W, 10'h004, 32'hDEADBEEF, 1'b0);
    ld(BU, 10'h004, 32'h000000EF, 1'b0);
    ld(BU, 10'h005, 32'h000000BE, 1'b0);
    ld(BU, 10'h006, 32'h000000AD, 1'b0);
    ld(BU, 10'h007, 32'h000000DE, 1'b0);
    ld(B, 10'h007, 32'hFFFFFFDE, 1'b0);
    ld(BU, 10'h007, 32'h000000DE, 1'b0);
    ld(H, 10'h006, 32'hFFFFDEAD, 1'b0);
    ld(HU, 10'h004, 32'h0000BEEF, 1'b0);

    st(W, 10'h3FE, 32'h11223344, TRAP);
    ld(W, 10'h3FE, 32'h11223344, TRAP);
    if (!TRAP) begin
      ld(BU, 10'h000, 32'h00000022, 1'b0);
      ld(BU, 10'h001, 32'h00000011, 1'b0);
    end

    st(B, 10'h020, 32'hFFFFFF7F, 1'b0);
    ld(B, 10'h020, 32'h0000007F, 1'b0);

    issue(1'b0, 3'b011, 10'h004, 32'd0, 1'b1, 32'd0);
    wait_idle();
    chk("err_cleared", 32'(bus.ERR), 32'd0);

    // Abort a store after two bytes have been written.
    st(W, 10'h010, 32'h55667788, 1'b0);
    wait_idle();
    bus.REQ    = 1'b1;
    bus.WE     = 1'b1;
    bus.FUNCT3 = W;
    bus.ADDR   = 10'h010;
    bus.WDATA  = 32'hAABBCCDD;
    @(posedge CLK);
    #1;
    bus.REQ = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_done", 32'(bus.DONE), 32'd0);
    exp_last = 32'd0;
    @(negedge CLK);
    RST = 1'b0;
    ld(W, 10'h010, 32'h5566CCDD, 1'b0);

    // REQ held high with a moving address across a busy load.
    wait_idle();
    bus.REQ    = 1'b1;
    bus.WE     = 1'b0;
    bus.FUNCT3 = W;
    bus.ADDR   = 10'h004;
    @(posedge CLK);
    #1;
    push_exp(1'b0, 32'hDEADBEEF, 1'b0, 4);
    k = 0;
    do begin
      @(negedge CLK);
      bus.ADDR = bus.ADDR + 10'h040;
      k++;
    end while (bus.BUSY && k < 20);
    if (k >= 20) begin
      checks++;
      errors++;
      $display("FAIL held_req_timeout got BUSY=1 want 0");
    end
    bus.ADDR = 10'h3FE;
    @(posedge CLK);
    #1;
    bus.REQ = 1'b0;
    push_exp(TRAP, 32'h11223344, 1'b0, 4);

    wait_idle();
    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
